// File: rtl/stage_id_queue.sv
// Decode stage: fully decodes each accepted instruction and queues it in a DEPTH-entry FIFO toward issue.
// Latency: an entry pushed in cycle N is at the head in cycle N+1 at the earliest (no bypass).
// Backpressure: in_ready drops when full, paused, flushing or in reset; a full queue refuses pushes even while popping.
// Optional: define ID_ILLEGAL_DETECT_EN to flag unlisted/invalid encodings on out_illegal (they still queue as NOPs).
module stage_id_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_inst_cat,
    output logic [3:0]       out_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_rs1_req,
    output logic             out_rs2_req,
    output logic             out_rd_write,
    output logic             out_rd_load,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_jump,
    output logic             out_branch,
    output logic             out_pred_taken,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPI    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      cat;
        logic [3:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rs1_req;
        logic            rs2_req;
        logic            rd_write;
        logic            rd_load;
        logic [XLEN-1:0] imm;
        logic            jump;
        logic            branch;
        logic            pred;
        logic            illegal;
    } ent_t;

    ent_t             dec;
    ent_t             mem_q [DEPTH];
    ent_t             head_ent;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [2:0]       alu_cat;
    logic             do_push, do_pop;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];

    // ALU category shared by OP and OPI, selected by func3
    always_comb begin
        alu_cat = 3'd1;
        case (f3)
            3'b000:         alu_cat = 3'd0;
            3'b001, 3'b101: alu_cat = 3'd2;
            3'b010, 3'b011: alu_cat = 3'd3;
            default:        alu_cat = 3'd1;
        endcase
    end

    // Full decode of the incoming instruction into one queue entry
    always_comb begin
`ifdef ID_ILLEGAL_DETECT_EN
        logic illegal;
`endif
        dec      = '0;
        dec.pc   = in_pc;
        dec.pred = in_pred_taken;
        dec.rd   = in_inst[11:7];
        dec.rs1  = in_inst[19:15];
        dec.rs2  = in_inst[24:20];
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                dec.imm      = XLEN'($signed({in_inst[31:12], 12'b0}));
                dec.rd_write = 1'b1;
            end
            OPC_JAL: begin
                dec.imm      = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
                dec.rd_write = 1'b1;
                dec.jump     = 1'b1;
            end
            OPC_JALR: begin
                dec.imm      = XLEN'($signed(in_inst[31:20]));
                dec.rd_write = 1'b1;
                dec.rs1_req  = 1'b1;
                dec.jump     = 1'b1;
                dec.branch   = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm     = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
                dec.rs1_req = 1'b1;
                dec.rs2_req = 1'b1;
                dec.cat     = 3'd4;
                dec.op      = {1'b0, f3};
                dec.branch  = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm      = XLEN'($signed(in_inst[31:20]));
                dec.rd_write = 1'b1;
                dec.rd_load  = 1'b1;
                dec.rs1_req  = 1'b1;
                dec.cat      = 3'd5;
                dec.op       = {1'b0, f3};
            end
            OPC_STORE: begin
                dec.imm     = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
                dec.rs1_req = 1'b1;
                dec.rs2_req = 1'b1;
                dec.cat     = 3'd6;
                dec.op      = {1'b0, f3};
            end
            OPC_OPI: begin
                // Shifts carry an unsigned shamt rather than a signed immediate
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    dec.imm = XLEN'(in_inst[24:20]);
                end else begin
                    dec.imm = XLEN'($signed(in_inst[31:20]));
                end
                dec.rd_write = 1'b1;
                dec.rs1_req  = 1'b1;
                dec.cat      = alu_cat;
                dec.op       = {(f3 == 3'b101) & in_inst[30], f3};
            end
            OPC_OP: begin
                dec.rd_write = 1'b1;
                dec.rs1_req  = 1'b1;
                dec.rs2_req  = 1'b1;
                dec.cat      = alu_cat;
                dec.op       = {in_inst[30], f3};
            end
            default: ;
        endcase
`ifdef ID_ILLEGAL_DETECT_EN
        illegal = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_OPI: illegal = 1'b0;
            OPC_OP:     illegal = (in_inst[31:25] != 7'b0000000) && (in_inst[31:25] != 7'b0100000);
            OPC_BRANCH: illegal = (f3 == 3'b010) || (f3 == 3'b011);
            default:    illegal = 1'b1;
        endcase
        // Illegal encodings still flow down the pipe, but as side-effect-free NOPs
        if (illegal) begin
            dec.cat      = '0;
            dec.op       = '0;
            dec.imm      = '0;
            dec.rs1_req  = 1'b0;
            dec.rs2_req  = 1'b0;
            dec.rd_write = 1'b0;
            dec.rd_load  = 1'b0;
            dec.jump     = 1'b0;
            dec.branch   = 1'b0;
            dec.illegal  = 1'b1;
        end
`endif
        // x0 is hardwired: never request a read of it nor schedule a write to it
        if (dec.rs1 == 5'd0) dec.rs1_req  = 1'b0;
        if (dec.rs2 == 5'd0) dec.rs2_req  = 1'b0;
        if (dec.rd  == 5'd0) dec.rd_write = 1'b0;
    end

    assign in_ready  = !rst_in && rdy_in && !flush_in && (cnt_q != CNT_W'(DEPTH));
    assign out_valid = rdy_in && (cnt_q != '0);
    assign do_push   = in_valid && in_ready;
    assign do_pop    = out_valid && out_ready && rdy_in;

    // Pointer/occupancy next state; flush wins over any pop or push
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_in) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_pop)  head_d = head_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Queue state and storage; reset clears entries so outputs read zero afterwards
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (do_push) mem_q[tail_q] <= dec;
        end
    end

    assign head_ent       = mem_q[head_q];
    assign out_pc         = head_ent.pc;
    assign out_inst_cat   = head_ent.cat;
    assign out_op         = head_ent.op;
    assign out_rd         = head_ent.rd;
    assign out_rs1        = head_ent.rs1;
    assign out_rs2        = head_ent.rs2;
    assign out_rs1_req    = head_ent.rs1_req;
    assign out_rs2_req    = head_ent.rs2_req;
    assign out_rd_write   = head_ent.rd_write;
    assign out_rd_load    = head_ent.rd_load;
    assign out_imm        = head_ent.imm;
    assign out_jump       = head_ent.jump;
    assign out_branch     = head_ent.branch;
    assign out_pred_taken = head_ent.pred;
    assign out_illegal    = head_ent.illegal;
    assign count          = cnt_q;
endmodule

// File: tb/tb_stage_id_queue.sv
// Bench for stage_id_queue: random and directed traffic against a queue-based reference model.
// Inputs are driven on the falling edge, outputs sampled 1 time unit later.
// Optional: compile with ID_ILLEGAL_DETECT_EN to match an RTL build with illegal detection.
module tb_stage_id_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, flush_in, in_valid, in_ready, in_pred_taken;
    logic [XLEN-1:0]  in_pc;
    logic [31:0]      in_inst;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_pc, out_imm;
    logic [2:0]       out_inst_cat;
    logic [3:0]       out_op;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic             out_rs1_req, out_rs2_req, out_rd_write, out_rd_load;
    logic             out_jump, out_branch, out_pred_taken, out_illegal;
    logic [CNT_W-1:0] count;

    always #5 clk_in = ~clk_in;

    stage_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_pred_taken(in_pred_taken), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst_cat(out_inst_cat), .out_op(out_op), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs1_req(out_rs1_req), .out_rs2_req(out_rs2_req),
        .out_rd_write(out_rd_write), .out_rd_load(out_rd_load), .out_imm(out_imm),
        .out_jump(out_jump), .out_branch(out_branch), .out_pred_taken(out_pred_taken),
        .out_illegal(out_illegal), .count(count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cat;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_req;
        logic        rs2_req;
        logic        rd_write;
        logic        rd_load;
        logic [31:0] imm;
        logic        jump;
        logic        branch;
        logic        pred;
        logic        illegal;
    } ent_t;

    ent_t model_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   just_reset = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] cat_of(input int f3);
        if (f3 == 0) return 3'd0;
        if (f3 == 1 || f3 == 5) return 3'd2;
        if (f3 == 2 || f3 == 3) return 3'd3;
        return 3'd1;
    endfunction

    // Reference decode: immediates built arithmetically from bit weights
    function automatic ent_t ref_decode(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
        ent_t        e;
        int          f3;
        logic [6:0]  opc;
        logic [31:0] sgn;
        bit          ill;
        e   = '0;
        opc = inst[6:0];
        f3  = int'(inst[14:12]);
        sgn = inst[31] ? 32'd4096 : 32'd0;
        ill = 0;
        e.pc = pc; e.pred = pred;
        e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
        case (opc)
            7'h37, 7'h17: begin e.imm = inst & 32'hFFFFF000; e.rd_write = 1; end
            7'h6F: begin
                e.imm = 32'(inst[30:21]) * 2 + 32'(inst[20]) * 2048 + 32'(inst[19:12]) * 4096
                        - (inst[31] ? 32'h0010_0000 : 32'd0);
                e.rd_write = 1; e.jump = 1;
            end
            7'h67: begin
                e.imm = 32'(inst[31:20]) - sgn;
                e.rd_write = 1; e.rs1_req = 1; e.jump = 1; e.branch = 1;
            end
            7'h63: begin
                e.imm = 32'(inst[11:8]) * 2 + 32'(inst[30:25]) * 32 + 32'(inst[7]) * 2048 - sgn;
                e.rs1_req = 1; e.rs2_req = 1; e.cat = 4; e.op = 4'(f3); e.branch = 1;
                ill = (f3 == 2 || f3 == 3);
            end
            7'h03: begin
                e.imm = 32'(inst[31:20]) - sgn;
                e.rd_write = 1; e.rd_load = 1; e.rs1_req = 1; e.cat = 5; e.op = 4'(f3);
            end
            7'h23: begin
                e.imm = 32'(inst[31:25]) * 32 + 32'(inst[11:7]) - sgn;
                e.rs1_req = 1; e.rs2_req = 1; e.cat = 6; e.op = 4'(f3);
            end
            7'h13: begin
                e.imm = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : 32'(inst[31:20]) - sgn;
                e.rd_write = 1; e.rs1_req = 1; e.cat = cat_of(f3);
                e.op = 4'(f3) + ((f3 == 5 && inst[30]) ? 4'd8 : 4'd0);
            end
            7'h33: begin
                e.rd_write = 1; e.rs1_req = 1; e.rs2_req = 1; e.cat = cat_of(f3);
                e.op = 4'(f3) + (inst[30] ? 4'd8 : 4'd0);
                ill = !(inst[31:25] == 7'h00 || inst[31:25] == 7'h20);
            end
            default: ill = 1;
        endcase
`ifdef ID_ILLEGAL_DETECT_EN
        if (ill) begin
            e.cat = 0; e.op = 0; e.imm = 0; e.rs1_req = 0; e.rs2_req = 0;
            e.rd_write = 0; e.rd_load = 0; e.jump = 0; e.branch = 0; e.illegal = 1;
        end
`else
        ill = 0;
`endif
        if (e.rs1 == 0) e.rs1_req = 0;
        if (e.rs2 == 0) e.rs2_req = 0;
        if (e.rd == 0)  e.rd_write = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  o;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: o = 7'h37; 1: o = 7'h17; 2: o = 7'h6F; 3: o = 7'h67; 4: o = 7'h63;
            5: o = 7'h03; 6: o = 7'h23; 7: o = 7'h13; 8: o = 7'h33;
            default: o = 7'(w[6:0] | 7'h04) ^ 7'h08;
        endcase
        if (o == 7'h33 && $urandom_range(0, 3) != 0) w[31:25] = {1'b0, w[30], 5'b0};
        if ($urandom_range(0, 7) == 0) w[11:7]  = 5'd0;
        if ($urandom_range(0, 7) == 0) w[19:15] = 5'd0;
        if ($urandom_range(0, 7) == 0) w[24:20] = 5'd0;
        return {w[31:7], o};
    endfunction

    // One clock cycle: drive, check against the model, then advance the model
    task automatic cyc(input bit r, input bit rd, input bit fl, input bit v,
                       input logic [31:0] inst, input bit ordy);
        ent_t        got;
        int          n;
        bit          push, pop;
        logic [31:0] pc;
        logic        pr;
        @(negedge clk_in);
        pc = $urandom;
        pr = 1'($urandom_range(0, 1));
        rst_in = r; rdy_in = rd; flush_in = fl; in_valid = v; in_inst = inst;
        in_pc = pc; in_pred_taken = pr; out_ready = ordy;
        #1;
        n = model_q.size();
        chk("in_ready", in_ready, (!r && rd && !fl && n != DEPTH));
        chk("out_valid", out_valid, (rd && n != 0));
        chk("count", count, n);
        got = {out_pc, out_inst_cat, out_op, out_rd, out_rs1, out_rs2, out_rs1_req, out_rs2_req,
               out_rd_write, out_rd_load, out_imm, out_jump, out_branch, out_pred_taken, out_illegal};
        if (just_reset) chk("reset_fields", got, '0);
        else if (n != 0) chk("head", got, model_q[0]);
        just_reset = 0;
        push = !r && v && rd && !fl && n != DEPTH;
        pop  = rd && n != 0 && ordy;
        if (r) begin
            model_q.delete();
            just_reset = 1;
        end else if (fl) begin
            model_q.delete();
        end else begin
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(ref_decode(inst, pc, pr));
        end
        @(posedge clk_in);
    endtask

    initial begin
        rst_in = 1; rdy_in = 0; flush_in = 0; in_valid = 0; in_inst = 0;
        in_pc = 0; in_pred_taken = 0; out_ready = 0;
        repeat (2) @(posedge clk_in);
        just_reset = 1;
        cyc(1, 1, 0, 1, 32'h00500093, 1);

        // addi x1,x0,5 through to the head
        cyc(0, 1, 0, 1, 32'h00500093, 1);
        #2;
        chk("addi_vld", out_valid, 1);
        chk("addi_cat", out_inst_cat, 0);
        chk("addi_op", out_op, 4'b0000);
        chk("addi_imm", out_imm, 5);
        chk("addi_rd", out_rd, 1);
        chk("addi_rdw", out_rd_write, 1);
        chk("addi_rs1req", out_rs1_req, 0);
        chk("addi_rs2req", out_rs2_req, 0);
        cyc(0, 1, 0, 0, 32'h0, 1);

        // lw then sub, held until inspected
        cyc(0, 1, 0, 1, 32'h0080A103, 0);
        cyc(0, 1, 0, 1, 32'h402081B3, 0);
        #2;
        chk("lw_cat", out_inst_cat, 5);
        chk("lw_op", out_op, 4'b0010);
        chk("lw_imm", out_imm, 8);
        chk("lw_load", out_rd_load, 1);
        cyc(0, 1, 0, 0, 32'h0, 1);
        #2;
        chk("sub_cat", out_inst_cat, 0);
        chk("sub_op", out_op, 4'b1000);
        chk("sub_rs1req", out_rs1_req, 1);
        chk("sub_rs2req", out_rs2_req, 1);
        cyc(0, 1, 0, 0, 32'h0, 1);

        // Fill to DEPTH, refuse a fifth, then pop, then push+pop together
        repeat (4) cyc(0, 1, 0, 1, rand_inst(), 0);
        cyc(0, 1, 0, 1, rand_inst(), 0);
        #2;
        chk("full_count", count, 4);
        chk("full_ready", in_ready, 0);
        cyc(0, 1, 0, 0, 32'h0, 1);
        cyc(0, 1, 0, 1, rand_inst(), 1);
        #2;
        chk("pushpop_count", count, 3);
        repeat (4) cyc(0, 1, 0, 0, 32'h0, 1);

        // Flush with a simultaneous push
        repeat (3) cyc(0, 1, 0, 1, rand_inst(), 0);
        cyc(0, 1, 1, 1, rand_inst(), 1);
        #2;
        chk("flush_count", count, 0);
        chk("flush_vld", out_valid, 0);
        cyc(0, 1, 0, 0, 32'h0, 1);

        // Global pause holds everything
        repeat (2) cyc(0, 1, 0, 1, rand_inst(), 0);
        repeat (3) cyc(0, 0, 0, 1, rand_inst(), 1);
        cyc(0, 1, 0, 0, 32'h0, 0);
        repeat (3) cyc(0, 1, 0, 0, 32'h0, 1);

        // All-ones encoding
        cyc(0, 1, 0, 1, 32'hFFFFFFFF, 0);
        #2;
`ifdef ID_ILLEGAL_DETECT_EN
        chk("ones_illegal", out_illegal, 1);
`else
        chk("ones_illegal", out_illegal, 0);
`endif
        chk("ones_rdw", out_rd_write, 0);
        cyc(0, 1, 0, 0, 32'h0, 1);

        // Random traffic including occasional flush and mid-stream reset
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0, rand_inst(), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
